// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl: register scoreboard for the MIPS/DLX decode stage.
// Tracks registers with a write in flight, stalls decode on RAW/WAW hazards,
// and releases them when writeback commits. A flush squashes all writers.
// A saturating stall counter raises a sticky err_deadlock flag.
// Optional feature macro: WB_BYPASS_EN (write-first bank; a same-cycle
// writeback hides its own pending bit from the hazard checks).
module reg_scoreboard_ctrl #(
  parameter int NREGS     = 32,
  parameter int ADDR_W    = 5,
  parameter int STALL_MAX = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_ra,
  input  logic [ADDR_W-1:0] id_rb,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic              id_wr,
  input  logic [ADDR_W-1:0] id_rw,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rw,
  input  logic              flush,
  output logic              id_stall,
  output logic              issue,
  output logic [NREGS-1:0]  pending,
  output logic              err_deadlock
);

  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);
  localparam logic [7:0] CNT_SAT   = 8'hFF;

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] busy;
  logic             hazard_ra;
  logic             hazard_rb;
  logic             hazard_waw;
  logic [7:0]       stall_cnt;
  logic [7:0]       stall_cnt_inc;

  // One-hot masks for the bit a committing writeback clears and the bit an
  // issuing writer sets; r0 never appears in either.
  always_comb begin
    // NOTE: every variable gets a default before the conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    clr_mask = '0;
    set_mask = '0;
    if (wb_valid && wb_rw != '0) clr_mask[wb_rw] = 1'b1;
    if (issue && id_wr && id_rw != '0) set_mask[id_rw] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  // Write-first bank: the register committing this cycle is readable now.
  assign busy = pending & ~clr_mask;
`else
  // Clocked bank write: a register stays busy through its writeback cycle.
  assign busy = pending;
`endif

  assign hazard_ra  = id_use_ra & (id_ra != '0) & busy[id_ra];
  assign hazard_rb  = id_use_rb & (id_rb != '0) & busy[id_rb];
  assign hazard_waw = id_wr     & (id_rw != '0) & busy[id_rw];

  assign id_stall = id_valid & (hazard_ra | hazard_rb | hazard_waw);
  assign issue    = id_valid & ~id_stall & ~flush;

  assign stall_cnt_inc = (stall_cnt == CNT_SAT) ? CNT_SAT : stall_cnt + 8'd1;

  // Busy vector: flush wins over everything, then set wins over clear since
  // the new writer is younger than the one committing.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the busy bits are control state, not bulk storage, so every bit
    // is reset; a stale 1 after reset would stall decode forever.
    if (!reset_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignment for all clocked state so every flop
      // samples pre-edge values regardless of block ordering.
      pending <= ((pending & ~clr_mask) | set_mask) & ~{{(NREGS-1){1'b0}}, 1'b1};
    end
  end

  // Consecutive-stall counter with a sticky deadlock flag once it reaches
  // the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt    <= '0;
      err_deadlock <= 1'b0;
    end else begin
      if (id_stall) begin
        stall_cnt <= stall_cnt_inc;
        if (stall_cnt_inc >= STALL_LIM) err_deadlock <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Directed self-checking bench for reg_scoreboard_ctrl. Inputs change 1 ns
// after the rising edge; combinational outputs are checked before the next
// edge and registered outputs after it.
module tb_reg_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_ra;
  logic [4:0]  id_rb;
  logic        id_use_ra;
  logic        id_use_rb;
  logic        id_wr;
  logic [4:0]  id_rw;
  logic        wb_valid;
  logic [4:0]  wb_rw;
  logic        flush;
  logic        id_stall;
  logic        issue;
  logic [31:0] pending;
  logic        err_deadlock;

  int total = 0;
  int bad   = 0;

  reg_scoreboard_ctrl #(.NREGS(32), .ADDR_W(5), .STALL_MAX(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .id_use_ra    (id_use_ra),
    .id_use_rb    (id_use_rb),
    .id_wr        (id_wr),
    .id_rw        (id_rw),
    .wb_valid     (wb_valid),
    .wb_rw        (wb_rw),
    .flush        (flush),
    .id_stall     (id_stall),
    .issue        (issue),
    .pending      (pending),
    .err_deadlock (err_deadlock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_ra = 0; id_rb = 0; id_use_ra = 0; id_use_rb = 0;
    id_wr = 0; id_rw = 0; wb_valid = 0; wb_rw = 0; flush = 0;
  endtask

  // Present a hazard-free writer to rd for one edge.
  task automatic issue_writer(input logic [4:0] rd);
    idle();
    id_valid = 1; id_wr = 1; id_rw = rd;
    tick();
  endtask

  task automatic stall_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle();
    reset_n = 0;
    #12;
    check("rst_pending", pending, 32'h0);
    check("rst_err", {31'b0, err_deadlock}, 32'h0);
    check("rst_stall", {31'b0, id_stall}, 32'h0);
    check("rst_issue", {31'b0, issue}, 32'h0);
    reset_n = 1;
    tick();

    // Writer to r3; visible one edge later.
    id_valid = 1; id_wr = 1; id_rw = 3;
    #1;
    check("w3_issue", {31'b0, issue}, 32'h1);
    tick();
    check("w3_pending", pending, 32'h0000_0008);

    // RAW on r3, then writeback of r3.
    idle();
    id_valid = 1; id_ra = 3; id_use_ra = 1;
    #1;
    check("raw_stall", {31'b0, id_stall}, 32'h1);
    check("raw_issue", {31'b0, issue}, 32'h0);
    wb_valid = 1; wb_rw = 3;
    #1;
`ifdef WB_BYPASS_EN
    check("raw_wb_stall", {31'b0, id_stall}, 32'h0);
    check("raw_wb_issue", {31'b0, issue}, 32'h1);
`else
    check("raw_wb_stall", {31'b0, id_stall}, 32'h1);
    check("raw_wb_issue", {31'b0, issue}, 32'h0);
`endif
    tick();
    wb_valid = 0; wb_rw = 0;
    #1;
    check("raw_after_pending", pending, 32'h0);
    check("raw_after_stall", {31'b0, id_stall}, 32'h0);
    check("raw_after_issue", {31'b0, issue}, 32'h1);

    // r5 busy; writer to r6 while r5 commits.
    issue_writer(5);
    check("w5_pending", pending, 32'h0000_0020);
    idle();
    id_valid = 1; id_wr = 1; id_rw = 6; wb_valid = 1; wb_rw = 5;
    #1;
    check("w6_issue", {31'b0, issue}, 32'h1);
    tick();
    check("w6_pending", pending, 32'h0000_0040);
    // Set and clear of r7 in one cycle: set wins.
    idle();
    id_valid = 1; id_wr = 1; id_rw = 7; wb_valid = 1; wb_rw = 7;
    tick();
    check("w7_setwins", pending, 32'h0000_00C0);
    // WAW on busy r6.
    idle();
    id_valid = 1; id_wr = 1; id_rw = 6;
    #1;
    check("waw_stall", {31'b0, id_stall}, 32'h1);
    tick();
    check("waw_pending", pending, 32'h0000_00C0);

    // r0 never stalls and is never marked.
    idle();
    id_valid = 1; id_ra = 0; id_use_ra = 1; id_wr = 1; id_rw = 0;
    #1;
    check("r0_stall", {31'b0, id_stall}, 32'h0);
    check("r0_issue", {31'b0, issue}, 32'h1);
    tick();
    check("r0_pending", pending, 32'h0000_00C0);

    // Flush with nothing in decode clears everything.
    idle();
    flush = 1;
    tick();
    check("flush0_pending", pending, 32'h0);

    // Build 0xF000 then flush alongside a hazard-free writer and a writeback.
    for (int r = 12; r < 16; r++) issue_writer(5'(r));
    check("f000_pending", pending, 32'h0000_F000);
    idle();
    id_valid = 1; id_wr = 1; id_rw = 20; wb_valid = 1; wb_rw = 12; flush = 1;
    #1;
    check("flush_issue", {31'b0, issue}, 32'h0);
    check("flush_stall", {31'b0, id_stall}, 32'h0);
    tick();
    check("flush_pending", pending, 32'h0);

    // Stall counter clears on a non-stall cycle.
    issue_writer(9);
    idle();
    id_valid = 1; id_ra = 9; id_use_ra = 1;
    stall_cycles(40);
    id_valid = 0;
    tick();
    id_valid = 1;
    stall_cycles(40);
    check("cnt_clear_err", {31'b0, err_deadlock}, 32'h0);
    id_valid = 0;
    tick();

    // Deadlock: flag sets on the edge ending the 64th stall cycle.
    id_valid = 1;
    #1;
    check("dl_stall", {31'b0, id_stall}, 32'h1);
    stall_cycles(63);
    check("dl_63_err", {31'b0, err_deadlock}, 32'h0);
    tick();
    check("dl_64_err", {31'b0, err_deadlock}, 32'h1);
    idle();
    stall_cycles(3);
    check("dl_sticky", {31'b0, err_deadlock}, 32'h1);
    check("dl_pending", pending, 32'h0000_0200);
    reset_n = 0;
    #3;
    check("dl_rst_err", {31'b0, err_deadlock}, 32'h0);
    check("dl_rst_pending", pending, 32'h0);
    reset_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
